// File: rtl/bus_timer_pkg.sv
// rtl/bus_timer_pkg.sv - shared register map, bit positions and encodings for bus_timer
package bus_timer_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int PRESCALE_W = 16;

    // Register offset is the word index addr[OFF_MSB:OFF_LSB].
    localparam int OFF_LSB = 2;
    localparam int OFF_MSB = 4;

    localparam logic [OFF_MSB-OFF_LSB:0] OFF_CTRL     = 3'd0;
    localparam logic [OFF_MSB-OFF_LSB:0] OFF_PRESET   = 3'd1;
    localparam logic [OFF_MSB-OFF_LSB:0] OFF_COUNT    = 3'd2;
    localparam logic [OFF_MSB-OFF_LSB:0] OFF_STATUS   = 3'd3;
    localparam logic [OFF_MSB-OFF_LSB:0] OFF_PRESCALE = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 2;
    localparam int STATUS_IP = 0;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

    typedef struct packed {
        logic im;
        logic mode;
        logic en;
    } ctrl_t;

    // Places the CTRL fields at their architectural bit positions.
    function automatic logic [DATA_W-1:0] ctrl_word(input ctrl_t c);
        logic [DATA_W-1:0] w;
        w            = '0;
        w[CTRL_EN]   = c.en;
        w[CTRL_MODE] = c.mode;
        w[CTRL_IM]   = c.im;
        return w;
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// rtl/bus_timer_prescaler.sv - tick divider, one tick every div+1 enabled cycles
//   clk, rst (async active-low) : clock and reset
//   en   : counting enable; counter held clear while low
//   load : divisor being rewritten; counter cleared, no tick this cycle
//   div  : terminal count
//   tick : one-cycle pulse at terminal count (combinational)
module bus_timer_prescaler
    import bus_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en || load) begin
            cnt_d = '0;
        end else if (cnt_q == div) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped down-counting timer with level interrupt
//   clk, rst (async active-low) : clock and reset
//   sel, dm_w, dm_r, addr, wdata, dm_op : peripheral bus (dm_op ignored, full-word only)
//   rdata : combinational read data, zero when no read is selected
//   irq   : IP & IM
//   Optional macro TIMER_PRESCALE_EN adds the PRESCALE register and tick divider.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int unsigned PRESET_RST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              dm_w,
    input  logic              dm_r,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        dm_op,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    logic [OFF_MSB-OFF_LSB:0] off;
    logic ctrl_we, preset_we, status_we;

    ctrl_t            ctrl_q, ctrl_d;
    logic             ip_q, ip_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              tick;
    logic              count_zero, dec, expire, reload;
    logic [DATA_W-1:0] prescale_rd;
    logic              unused_ok;

    assign off       = addr[OFF_MSB:OFF_LSB];
    assign ctrl_we   = sel && dm_w && (off == OFF_CTRL);
    assign preset_we = sel && dm_w && (off == OFF_PRESET);
    assign status_we = sel && dm_w && (off == OFF_STATUS);

    assign unused_ok = ^{dm_op, addr[ADDR_W-1:OFF_MSB+1], addr[OFF_LSB-1:0], wdata};

`ifdef TIMER_PRESCALE_EN
    logic                  prescale_we;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    assign prescale_we = sel && dm_w && (off == OFF_PRESCALE);
    assign prescale_rd = DATA_W'(prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        if (prescale_we) begin
            prescale_d = wdata[PRESCALE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    bus_timer_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q.en),
        .load (prescale_we),
        .div  (prescale_q),
        .tick (tick)
    );
`else
    assign tick        = ctrl_q.en;
    assign prescale_rd = '0;
`endif

    // A CTRL or PRESET write on the same edge pre-empts the tick entirely,
    // so neither a decrement nor an expiry happens on that edge.
    assign count_zero = (count_q == '0);
    assign dec        = tick && ctrl_q.en && !count_zero && !ctrl_we && !preset_we;
    assign expire     = dec && (count_q == CNT_W'(1));
    assign reload     = ctrl_q.en && (ctrl_q.mode == MODE_AUTO) && count_zero && !ctrl_we;

    always_comb begin
        ctrl_d   = ctrl_q;
        ip_d     = ip_q;
        preset_d = preset_q;
        count_d  = count_q;

        if (dec) begin
            count_d = count_q - 1'b1;
        end
        if (reload) begin
            count_d = preset_q;
        end
        if (expire && (ctrl_q.mode == MODE_ONESHOT)) begin
            ctrl_d.en = 1'b0;
        end
        if (ctrl_we) begin
            ctrl_d.en   = wdata[CTRL_EN];
            ctrl_d.mode = wdata[CTRL_MODE];
            ctrl_d.im   = wdata[CTRL_IM];
        end
        if (preset_we) begin
            preset_d = wdata[CNT_W-1:0];
            count_d  = wdata[CNT_W-1:0];
        end
        // Clear first so a simultaneous expiry leaves IP set.
        if (status_we && wdata[STATUS_IP]) begin
            ip_d = 1'b0;
        end
        if (expire) begin
            ip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            ip_q     <= 1'b0;
            preset_q <= CNT_W'(PRESET_RST);
            count_q  <= CNT_W'(PRESET_RST);
        end else begin
            ctrl_q   <= ctrl_d;
            ip_q     <= ip_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && dm_r) begin
            case (off)
                OFF_CTRL:     rdata = ctrl_word(ctrl_q);
                OFF_PRESET:   rdata = DATA_W'(preset_q);
                OFF_COUNT:    rdata = DATA_W'(count_q);
                OFF_STATUS:   rdata[STATUS_IP] = ip_q;
                OFF_PRESCALE: rdata = prescale_rd;
                default:      rdata = '0;
            endcase
        end
    end

    assign irq = ip_q && ctrl_q.im;

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - directed self-checking bench for bus_timer
module tb_bus_timer;

    localparam logic [2:0] R_CTRL = 3'd0, R_PRESET = 3'd1, R_COUNT = 3'd2,
                           R_STATUS = 3'd3, R_PRESCALE = 3'd4, R_HOLE = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, dm_w, dm_r;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  dm_op;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    bus_timer dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .dm_w  (dm_w),
        .dm_r  (dm_r),
        .addr  (addr),
        .wdata (wdata),
        .dm_op (dm_op),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        sel   = 1'b1;
        dm_w  = 1'b1;
        addr  = {27'd0, off, 2'b00};
        wdata = d;
        idle();
        sel   = 1'b0;
        dm_w  = 1'b0;
    endtask

    // Read occupying one cycle; sampled on the falling edge.
    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
        string       t;
        logic [31:0] e;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        sel  = 1'b1;
        dm_r = 1'b1;
        addr = {27'd0, off, 2'b00};
        @(negedge clk);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, rdata, e);
        idle();
        sel  = 1'b0;
        dm_r = 1'b0;
    endtask

    // Read without waiting for a clock edge (used while reset is held).
    task automatic rd_now(input logic [2:0] off, input logic [31:0] exp, input string tag);
        string       t;
        logic [31:0] e;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        sel  = 1'b1;
        dm_r = 1'b1;
        addr = {27'd0, off, 2'b00};
        #1;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, rdata, e);
        sel  = 1'b0;
        dm_r = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
        addr = '0; wdata = '0; dm_op = 3'd2;

        // Reset state
        #3;
        rd_now(R_CTRL,   32'h0, "rst_ctrl");
        rd_now(R_PRESET, 32'h0, "rst_preset");
        rd_now(R_COUNT,  32'h0, "rst_count");
        rd_now(R_STATUS, 32'h0, "rst_status");
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_rdata_idle", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        // One-shot: 3,2,1,0 then IP/irq and EN cleared
        wr(R_PRESET, 32'd3);
        wr(R_CTRL, 32'h5);
        rd(R_COUNT, 32'd3, "os_cnt3");
        rd(R_COUNT, 32'd2, "os_cnt2");
        rd(R_COUNT, 32'd1, "os_cnt1");
        rd(R_COUNT, 32'd0, "os_cnt0");
        chk("os_irq", {31'd0, irq}, 32'h1);
        rd(R_CTRL, 32'h4, "os_en_clr");
        rd(R_STATUS, 32'h1, "os_ip");
        rd(R_COUNT, 32'd0, "os_hold0");
        wr(R_STATUS, 32'h1);
        chk("os_irq_clr", {31'd0, irq}, 32'h0);

        // Auto-reload: 2,1,0,2,1,0
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h7);
        rd(R_COUNT, 32'd2, "ar_a2");
        rd(R_COUNT, 32'd1, "ar_a1");
        chk("ar_irq", {31'd0, irq}, 32'h1);
        rd(R_COUNT, 32'd0, "ar_a0");
        rd(R_COUNT, 32'd2, "ar_b2");
        rd(R_COUNT, 32'd1, "ar_b1");
        rd(R_COUNT, 32'd0, "ar_b0");
        wr(R_STATUS, 32'h1);
        chk("ar_irq_drop", {31'd0, irq}, 32'h0);
        wr(R_CTRL, 32'h0);

        // STATUS clear coinciding with expiry: set wins
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h5);
        idle();
        wr(R_STATUS, 32'h1);
        rd(R_STATUS, 32'h1, "coll_ip");
        chk("coll_irq", {31'd0, irq}, 32'h1);
        wr(R_STATUS, 32'h1);
        // Masked interrupt
        wr(R_PRESET, 32'd1);
        wr(R_CTRL, 32'h1);
        idle();
        chk("mask_irq", {31'd0, irq}, 32'h0);
        rd(R_STATUS, 32'h1, "mask_ip");
        wr(R_STATUS, 32'h1);
        wr(R_CTRL, 32'h0);

        // CTRL rewrite with EN=1 neither reloads nor ticks; PRESET write wins
        wr(R_PRESET, 32'd5);
        wr(R_CTRL, 32'h5);
        idle();
        wr(R_CTRL, 32'h5);
        rd(R_COUNT, 32'd4, "ctrl_wr_hold");
        wr(R_PRESET, 32'd7);
        rd(R_COUNT, 32'd7, "preset_wins");
        wr(R_CTRL, 32'h0);

        // PRESET=0: no count, no IP; hole offset; unselected accesses
        wr(R_PRESET, 32'd0);
        wr(R_CTRL, 32'h7);
        rd(R_COUNT, 32'd0, "z_cnt_a");
        rd(R_COUNT, 32'd0, "z_cnt_b");
        rd(R_COUNT, 32'd0, "z_cnt_c");
        rd(R_STATUS, 32'h0, "z_no_ip");
        rd(R_HOLE, 32'h0, "hole_0x14");
        sel = 1'b0; dm_w = 1'b1; addr = {27'd0, R_PRESET, 2'b00}; wdata = 32'd5;
        idle();
        dm_w = 1'b0;
        rd(R_PRESET, 32'd0, "nosel_wr");
        sel = 1'b0; dm_r = 1'b1; addr = {27'd0, R_CTRL, 2'b00};
        #1;
        chk("nosel_rd", rdata, 32'h0);
        dm_r = 1'b0;
        wr(R_CTRL, 32'h0);

`ifdef TIMER_PRESCALE_EN
        wr(R_PRESCALE, 32'd3);
        wr(R_PRESET, 32'd2);
        wr(R_CTRL, 32'h5);
        for (int k = 0; k <= 8; k++) begin
            rd(R_COUNT, (k < 4) ? 32'd2 : ((k < 8) ? 32'd1 : 32'd0), $sformatf("ps_cnt_%0d", k));
        end
        chk("ps_irq", {31'd0, irq}, 32'h1);
        rd(R_PRESCALE, 32'd3, "ps_reg");
        wr(R_STATUS, 32'h1);
        wr(R_PRESCALE, 32'd0);
`else
        wr(R_PRESCALE, 32'd3);
        rd(R_PRESCALE, 32'h0, "ps_absent");
`endif

        // Asynchronous reset mid-count
        wr(R_PRESET, 32'd1);
        wr(R_CTRL, 32'h5);
        idle();
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        wr(R_PRESET, 32'd10);
        wr(R_CTRL, 32'h5);
        idle();
        idle();
        rst = 1'b0;
        rd_now(R_COUNT,  32'h0, "arst_count");
        rd_now(R_CTRL,   32'h0, "arst_ctrl");
        rd_now(R_PRESET, 32'h0, "arst_preset");
        rd_now(R_STATUS, 32'h0, "arst_status");
        chk("arst_irq", {31'd0, irq}, 32'h0);
        idle();
        rst = 1'b1;
        idle();
        idle();
        idle();
        rd(R_COUNT, 32'd0, "post_rst_cnt");
        wr(R_PRESET, 32'd4);
        idle();
        idle();
        idle();
        rd(R_COUNT, 32'd4, "no_tick_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
